// File: rtl/approx_mac_acc_pkg.sv
// Shared types and constants for the approximate MAC accumulator.
// Overflow behaviour is selected by APPROX_MAC_SATURATE_EN (see approx_mac_acc.sv).
package approx_mac_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;

    localparam logic [3:0] SEG_W8 = 4'd8;
    localparam logic [3:0] SEG_W7 = 4'd7;
    localparam logic [3:0] SEG_W6 = 4'd6;
    localparam logic [3:0] SEG_W5 = 4'd5;

    // Operand bit groups that select the segment width.
    localparam int unsigned GRP8_HI  = 15;
    localparam int unsigned GRP8_LO  = 13;
    localparam int unsigned GRP7_HI  = 12;
    localparam int unsigned GRP7_LO  = 10;
    localparam int unsigned GRP6_BIT = 9;

    function automatic logic [3:0] lead_one(input logic [OP_W-1:0] v);
        lead_one = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            if (v[i]) lead_one = 4'(i);
        end
    endfunction

endpackage

// File: rtl/approx_seg_mult.sv
// Combinational segment-truncated approximate 16x16 multiplier.
// Keeps the top num bits of each operand below its leading one and re-shifts the product.
module approx_seg_mult
    import approx_mac_acc_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] prod
);

    logic [3:0]        num;
    logic [3:0]        ka;
    logic [3:0]        kb;
    logic [3:0]        sha;
    logic [3:0]        shb;
    logic [OP_W-1:0]   sega;
    logic [OP_W-1:0]   segb;
    logic [PROD_W-1:0] raw;

    always_comb begin
        if ((|a[GRP8_HI:GRP8_LO]) || (|b[GRP8_HI:GRP8_LO])) begin
            num = SEG_W8;
        end else if ((|a[GRP7_HI:GRP7_LO]) || (|b[GRP7_HI:GRP7_LO])) begin
            num = SEG_W7;
        end else if (a[GRP6_BIT] || b[GRP6_BIT]) begin
            num = SEG_W6;
        end else begin
            num = SEG_W5;
        end

        ka   = lead_one(a);
        kb   = lead_one(b);
        sha  = '0;
        shb  = '0;
        sega = a;
        segb = b;
        if (ka >= num) begin
            sha  = ka - num + 4'd1;
            sega = a >> sha;
        end
        if (kb >= num) begin
            shb  = kb - num + 4'd1;
            segb = b >> shb;
        end

        raw  = PROD_W'(sega) * PROD_W'(segb);
        prod = raw << (5'(sha) + 5'(shb));
    end

endmodule

// File: rtl/approx_mac_acc.sv
// Frame-based accumulator of approximate products with a one-stage product pipeline.
// Define APPROX_MAC_SATURATE_EN to clamp on overflow and flag it on out_ovf; otherwise the sum wraps.
module approx_mac_acc
    import approx_mac_acc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int unsigned     CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_q;
    logic              prod_vld;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf;
    logic              ovf_next;
    logic              accept;

    assign accept  = in_valid && in_ready;
    assign out_ovf = ovf;

    approx_seg_mult u_mult (
        .a    (in_a),
        .b    (in_b),
        .prod (prod)
    );

`ifdef APPROX_MAC_SATURATE_EN
    localparam int unsigned SUM_W = ACC_W + 1;
    logic [SUM_W-1:0] sum;

    // Once clamped the flag stays set, so later adds cannot pull the sum back below all-ones.
    always_comb begin
        sum      = {1'b0, acc} + SUM_W'(prod_q);
        acc_next = acc;
        ovf_next = ovf;
        if (prod_vld) begin
            if (ovf || sum[ACC_W]) begin
                acc_next = '1;
                ovf_next = 1'b1;
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        acc_next = acc;
        ovf_next = 1'b0;
        if (prod_vld) begin
            acc_next = acc + ACC_W'(prod_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prod_q    <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            prod_vld <= accept;
            if (accept) prod_q <= prod;
            acc <= acc_next;
            ovf <= ovf_next;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (FRAME_LEN == 1) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACC;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            state    <= DRAIN;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last product lands in the accumulator on this edge.
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_acc   <= acc_next;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        acc       <= '0;
                        ovf       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mac_acc.sv
// Self-checking bench: three approx_mac_acc instances (FRAME_LEN/ACC_W = 4/40, 16/40, 2/32)
// checked against a behavioural model; honours APPROX_MAC_SATURATE_EN like the design.
module tb_approx_mac_acc;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [ND];
    logic        in_ready  [ND];
    logic [15:0] in_a      [ND];
    logic [15:0] in_b      [ND];
    logic        out_valid [ND];
    logic        out_ready [ND];
    logic        out_ovf   [ND];
    logic [47:0] out_acc   [ND];
    logic [39:0] acc0;
    logic [39:0] acc1;
    logic [31:0] acc2;

    int n_tests = 0;
    int n_fails = 0;

    assign out_acc[0] = 48'(acc0);
    assign out_acc[1] = 48'(acc1);
    assign out_acc[2] = 48'(acc2);

    always #5 clk = ~clk;

    approx_mac_acc #(.FRAME_LEN(4), .ACC_W(40)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_acc(acc0), .out_ovf(out_ovf[0]));

    approx_mac_acc #(.FRAME_LEN(16), .ACC_W(40)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_acc(acc1), .out_ovf(out_ovf[1]));

    approx_mac_acc #(.FRAME_LEN(2), .ACC_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_acc(acc2), .out_ovf(out_ovf[2]));

    function automatic int fl(input int d);
        return (d == 0) ? 4 : (d == 1) ? 16 : 2;
    endfunction

    function automatic int aw(input int d);
        return (d == 2) ? 32 : 40;
    endfunction

    // Keep the top num significant bits of op; report how many low bits were dropped.
    function automatic longint unsigned seg_of(input longint unsigned op, input int num,
                                               output int drop);
        longint unsigned t;
        int nbits;
        drop = 0;
        if (op < (64'd1 << num)) return op;
        nbits = 0;
        t = op;
        while (t > 0) begin
            t = t >> 1;
            nbits++;
        end
        drop = nbits - num;
        return op >> drop;
    endfunction

    function automatic longint unsigned model_prod(input int unsigned a, input int unsigned b);
        int unsigned m;
        int num, da, db;
        longint unsigned sa, sb;
        m = (a > b) ? a : b;
        if (m >= 8192)      num = 8;
        else if (m >= 1024) num = 7;
        else if (m >= 512)  num = 6;
        else                num = 5;
        sa = seg_of(longint'(a), num, da);
        sb = seg_of(longint'(b), num, db);
        return ((sa * sb) << (da + db)) & 64'hFFFF_FFFF;
    endfunction

    function automatic void model_add(input int w, input longint unsigned p,
                                      inout longint unsigned sum, inout bit ovf);
        longint unsigned lim;
        lim = 64'd1 << w;
        sum = sum + p;
        if (sum >= lim) begin
`ifdef APPROX_MAC_SATURATE_EN
            sum = lim - 1;
            ovf = 1'b1;
`else
            sum = sum - lim;
`endif
        end
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        return v >> $urandom_range(0, 15);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_beat(input int d, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_valid[d] = 1'b1;
        in_a[d] = a;
        in_b[d] = b;
        while (!in_ready[d] && n < 50) begin
            step();
            n++;
        end
        n_tests++;
        if (!in_ready[d]) begin
            n_fails++;
            $display("FAIL send_beat dut%0d: in_ready=0 after %0d cycles, required 1", d, n);
        end
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output bit ok);
        for (int i = 0; i < 30 && !out_valid[d]; i++) step();
        ok = out_valid[d];
    endtask

    task automatic release_result(input int d);
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < ND; d++) begin
            n_tests += 4;
            if (in_ready[d] !== 1'b1) begin
                n_fails++; $display("FAIL reset_in_ready dut%0d: got %b, required 1", d, in_ready[d]);
            end
            if (out_valid[d] !== 1'b0) begin
                n_fails++; $display("FAIL reset_out_valid dut%0d: got %b, required 0", d, out_valid[d]);
            end
            if (out_acc[d] !== 48'd0) begin
                n_fails++; $display("FAIL reset_out_acc dut%0d: got %0h, required 0", d, out_acc[d]);
            end
            if (out_ovf[d] !== 1'b0) begin
                n_fails++; $display("FAIL reset_out_ovf dut%0d: got %b, required 0", d, out_ovf[d]);
            end
        end
    endtask

    task automatic test_small_frame();
        for (int i = 0; i < 4; i++) send_beat(0, 16'd3, 16'd5);
        n_tests++;
        if (out_valid[0] !== 1'b0) begin
            n_fails++; $display("FAIL small_latency_early: out_valid=%b one cycle after last accept, required 0", out_valid[0]);
        end
        step();
        n_tests += 4;
        if (out_valid[0] !== 1'b1) begin
            n_fails++; $display("FAIL small_latency: out_valid=%b two cycles after last accept, required 1", out_valid[0]);
        end
        if (out_acc[0] !== 48'd60) begin
            n_fails++; $display("FAIL small_acc: got %0d, required 60", out_acc[0]);
        end
        if (out_ovf[0] !== 1'b0) begin
            n_fails++; $display("FAIL small_ovf: got %b, required 0", out_ovf[0]);
        end
        if (in_ready[0] !== 1'b0) begin
            n_fails++; $display("FAIL small_in_ready_hold: got %b, required 0", in_ready[0]);
        end
        release_result(0);
    endtask

    task automatic test_max_operands();
        bit ok;
        for (int i = 0; i < 16; i++) send_beat(1, 16'hFFFF, 16'hFFFF);
        wait_valid(1, ok);
        n_tests += 3;
        if (!ok) begin
            n_fails++; $display("FAIL max_wait: out_valid=0 after timeout, required 1");
        end
        if (out_acc[1] !== 48'h0_FE01_00000) begin
            n_fails++; $display("FAIL max_acc: got %0h, required fe0100000", out_acc[1]);
        end
        if (out_ovf[1] !== 1'b0) begin
            n_fails++; $display("FAIL max_ovf: got %b, required 0", out_ovf[1]);
        end
        release_result(1);
    endtask

    task automatic test_overflow();
        bit ok;
        logic [47:0] exp_acc;
        logic        exp_ovf;
`ifdef APPROX_MAC_SATURATE_EN
        exp_acc = 48'hFFFF_FFFF;
        exp_ovf = 1'b1;
`else
        exp_acc = 48'hFC02_0000;
        exp_ovf = 1'b0;
`endif
        send_beat(2, 16'hFFFF, 16'hFFFF);
        send_beat(2, 16'hFFFF, 16'hFFFF);
        wait_valid(2, ok);
        n_tests += 3;
        if (!ok) begin
            n_fails++; $display("FAIL ovf_wait: out_valid=0 after timeout, required 1");
        end
        if (out_acc[2] !== exp_acc) begin
            n_fails++; $display("FAIL ovf_acc: got %0h, required %0h", out_acc[2], exp_acc);
        end
        if (out_ovf[2] !== exp_ovf) begin
            n_fails++; $display("FAIL ovf_flag: got %b, required %b", out_ovf[2], exp_ovf);
        end
        release_result(2);
    endtask

    task automatic test_backpressure();
        bit ok;
        longint unsigned sum;
        bit ovf;
        logic [15:0] a, b;
        sum = 0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = rand_op();
            b = rand_op();
            model_add(40, model_prod(a, b), sum, ovf);
            send_beat(0, a, b);
        end
        wait_valid(0, ok);
        // A beat offered while the result is held must be ignored.
        in_valid[0] = 1'b1;
        in_a[0] = 16'hFFFF;
        in_b[0] = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            n_tests += 3;
            if (out_valid[0] !== 1'b1) begin
                n_fails++; $display("FAIL bp_valid cycle %0d: got %b, required 1", c, out_valid[0]);
            end
            if (in_ready[0] !== 1'b0) begin
                n_fails++; $display("FAIL bp_in_ready cycle %0d: got %b, required 0", c, in_ready[0]);
            end
            if (out_acc[0] !== 48'(sum)) begin
                n_fails++; $display("FAIL bp_acc cycle %0d: got %0h, required %0h", c, out_acc[0], sum);
            end
            step();
        end
        release_result(0);
        in_valid[0] = 1'b0;
        n_tests += 2;
        if (in_ready[0] !== 1'b1) begin
            n_fails++; $display("FAIL bp_in_ready_after: got %b, required 1", in_ready[0]);
        end
        if (out_valid[0] !== 1'b0) begin
            n_fails++; $display("FAIL bp_valid_after: got %b, required 0", out_valid[0]);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        send_beat(0, 16'd100, 16'd100);
        send_beat(0, 16'd100, 16'd100);
        do_reset();
        n_tests += 2;
        if (in_ready[0] !== 1'b1) begin
            n_fails++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready[0]);
        end
        if (out_valid[0] !== 1'b0) begin
            n_fails++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid[0]);
        end
        for (int i = 0; i < 4; i++) send_beat(0, 16'd2, 16'd2);
        wait_valid(0, ok);
        n_tests += 2;
        if (!ok) begin
            n_fails++; $display("FAIL midrst_wait: out_valid=0 after timeout, required 1");
        end
        if (out_acc[0] !== 48'd16) begin
            n_fails++; $display("FAIL midrst_acc: got %0d, required 16", out_acc[0]);
        end
        release_result(0);
    endtask

    task automatic test_back_to_back();
        int accepts;
        int results;
        int c;
        accepts = 0;
        results = 0;
        c = 0;
        in_valid[0]  = 1'b1;
        in_a[0]      = 16'd1;
        in_b[0]      = 16'd1;
        out_ready[0] = 1'b1;
        while (results < 2 && c < 60) begin
            if (in_ready[0]) accepts++;
            if (out_valid[0]) begin
                n_tests += 3;
                if (in_ready[0] !== 1'b0) begin
                    n_fails++; $display("FAIL b2b_in_ready_hold: got %b, required 0", in_ready[0]);
                end
                if (accepts != 4) begin
                    n_fails++; $display("FAIL b2b_accepts frame %0d: got %0d, required 4", results, accepts);
                end
                if (out_acc[0] !== 48'd4) begin
                    n_fails++; $display("FAIL b2b_acc frame %0d: got %0d, required 4", results, out_acc[0]);
                end
                accepts = 0;
                results++;
            end
            step();
            c++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        n_tests++;
        if (results != 2) begin
            n_fails++; $display("FAIL b2b_results: got %0d frames, required 2", results);
        end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        longint unsigned sum;
        bit ovf;
        logic [15:0] a, b;
        for (int f = 0; f < 12; f++) begin
            d = $urandom_range(0, ND - 1);
            sum = 0;
            ovf = 1'b0;
            for (int i = 0; i < fl(d); i++) begin
                a = rand_op();
                b = rand_op();
                model_add(aw(d), model_prod(a, b), sum, ovf);
                send_beat(d, a, b);
                repeat ($urandom_range(0, 2)) step();
            end
            wait_valid(d, ok);
            repeat ($urandom_range(0, 3)) step();
            n_tests += 3;
            if (!ok) begin
                n_fails++; $display("FAIL rand_wait frame %0d dut%0d: out_valid=0 after timeout", f, d);
            end
            if (out_acc[d] !== 48'(sum)) begin
                n_fails++; $display("FAIL rand_acc frame %0d dut%0d: got %0h, required %0h", f, d, out_acc[d], sum);
            end
            if (out_ovf[d] !== ovf) begin
                n_fails++; $display("FAIL rand_ovf frame %0d dut%0d: got %b, required %b", f, d, out_ovf[d], ovf);
            end
            release_result(d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_frame();
        test_max_operands();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/approx_mac_acc.md
APPROX_MAC_ACC -- requirements
Module: approx_mac_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning the number of operand pairs summed per frame (range 1..256).
REQ-002 SHALL have parameter ACC_W, default 40, meaning the accumulator and result width (range 32..48).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the pair this cycle.
REQ-007 SHALL have ports in_a and in_b, input, 16 each, unsigned operands.
REQ-008 SHALL have port out_valid, output, 1, meaning the frame result is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port out_acc, output, ACC_W, the frame sum of approximate products.
REQ-011 SHALL have port out_ovf, output, 1, meaning the accumulator overflowed during the frame.

Function
REQ-012 A beat SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-013 The approximate product SHALL follow these steps:
- Segment width: num = 8 if any of a[15:13] or b[15:13] is set; else 7 if any of a[12:10] or b[12:10] is set; else 6 if a[9] or b[9] is set; else 5.
- Per operand, k is the leading-one index (0 for a zero operand).
- If k < num, the operand is used exactly with shift 0.
- Otherwise the retained bits are op[k:k-num+1] with shift k-num+1.
- Product = seg_a * seg_b << (shift_a + shift_b), 32 bits.
REQ-014 The product SHALL be registered on the accept edge; the accumulator SHALL add it on the following edge, giving 1-cycle pipeline latency.
REQ-015 The FSM SHALL have four states: IDLE, ACC, DRAIN, HOLD.
- IDLE -> ACC on the first accepted beat.
- ACC -> DRAIN when beat FRAME_LEN is accepted; with FRAME_LEN = 1, IDLE -> DRAIN directly.
- DRAIN -> HOLD after one cycle.
- HOLD -> IDLE on out_valid && out_ready.
REQ-016 in_ready SHALL be 1 in IDLE and ACC and 0 in DRAIN and HOLD.
REQ-017 The beat counter SHALL count 0..FRAME_LEN-1, clear on frame completion, and never wrap mid-frame.
REQ-018 out_valid SHALL be 1 only in HOLD; out_acc and out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-019 On the HOLD -> IDLE edge, the accumulator and out_ovf SHALL clear, so the next frame starts from 0.
REQ-020 The accumulator SHALL add the zero-extended product modulo 2^ACC_W, unless REQ-027 applies.
REQ-021 A beat offered during DRAIN or HOLD SHALL NOT be accepted and SHALL NOT affect the current result.

Reset
REQ-022 On rst = 1, the state SHALL become IDLE and the counter, product register, accumulator, out_acc and out_ovf SHALL clear to 0.
REQ-023 On rst = 1, out_valid SHALL be 0 and in_ready SHALL be 1 from the first post-reset cycle.
REQ-024 A reset mid-frame or during HOLD SHALL discard partial sums; no stale product SHALL be added after reset.
REQ-025 Reset SHALL take priority over a simultaneous accept or output handshake.

Configuration
REQ-026 Macro APPROX_MAC_SATURATE_EN SHALL select the overflow behaviour.
REQ-027 With APPROX_MAC_SATURATE_EN defined:
- An addition exceeding 2^ACC_W-1 SHALL clamp the accumulator to all ones.
- out_ovf SHALL set and stay set until frame end.
- Later adds in the frame SHALL keep the accumulator clamped.
REQ-028 Without APPROX_MAC_SATURATE_EN, the accumulator SHALL wrap and out_ovf SHALL be 0 at all times.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state enum;
- the segment-width constants (8, 7, 6, 5) and their bit-group thresholds;
- the 32-bit product width constant.
REQ-030 The combinational approximate product of REQ-013 SHALL be one sub-module, approx_seg_mult; the FSM, counter, pipeline and accumulator SHALL be in approx_mac_acc.

Verification
REQ-031 The bench SHALL run: FRAME_LEN=4, four beats a=3, b=5 -> out_acc=60, out_ovf=0, out_valid rising 2 cycles after the 4th accept.
REQ-032 The bench SHALL run: FRAME_LEN=16, sixteen beats a=b=16'hFFFF -> each product 0xFE010000, out_acc=0xFE0100000.
REQ-033 The bench SHALL run: ACC_W=32, FRAME_LEN=2, two beats a=b=16'hFFFF:
- with APPROX_MAC_SATURATE_EN -> out_acc=0xFFFFFFFF, out_ovf=1;
- without it -> out_acc=0xFC020000, out_ovf=0.
REQ-034 The bench SHALL run: frame done with out_ready held 0 for 5 cycles -> out_valid=1, in_ready=0 and out_acc stable throughout; accept on cycle 6, then in_ready=1 next cycle.
REQ-035 The bench SHALL run: FRAME_LEN=4, rst pulsed after 2 accepts of a=b=100, then four beats a=b=2 -> out_acc=16.
REQ-036 The bench SHALL run: in_valid held 1 continuously over two frames of a=b=1 -> exactly FRAME_LEN accepts per frame, no beats accepted in DRAIN or HOLD, both results equal FRAME_LEN.
